// File: rtl/shift_deserializer.sv
// Rebuilds FROM-bit frames from TO-bit words, MSB word first, framed by sof_i.
// Ports: clk, reset (async high), data_i/valid_i/sof_i in; data_o, valid_o, sync_o, err_o out;
// optional (DESER_ERRCNT_EN): err_clr_i in, err_cnt_o out.
module shift_deserializer #(
  parameter int FROM     = 32,
  parameter int LOG2FROM = 5,
  parameter int TO       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [TO-1:0]   data_i,
  input  logic            valid_i,
  input  logic            sof_i,
  output logic [FROM-1:0] data_o,
  output logic            valid_o,
  output logic            sync_o,
  output logic            err_o
`ifdef DESER_ERRCNT_EN
  ,
  input  logic            err_clr_i,
  output logic [7:0]      err_cnt_o
`endif
);

  localparam int N  = FROM / TO;
  localparam int CW = LOG2FROM + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    HUNT,
    COLLECT,
    WAIT_SOF
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FROM-1:0] sh_q, sh_d;
  logic [FROM-1:0] data_d;
  logic            valid_d;
  logic            err_d;
  logic [FROM-1:0] shifted;
  logic [FROM-1:0] first;

  assign shifted = {sh_q[FROM-TO-1:0], data_i};
  assign first   = FROM'(data_i);
  assign sync_o  = (state_q != HUNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_o  <= data_d;
      valid_o <= valid_d;
      err_o   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_o;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (sof_i) begin
            sh_d    = first;
            cnt_d   = CW'(1);
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (sof_i) begin
            // Early SOF: drop partial frame, restart on this word.
            err_d = 1'b1;
            sh_d  = first;
            cnt_d = CW'(1);
          end else begin
            sh_d = shifted;
            if (cnt_q == LAST) begin
              data_d  = shifted;
              valid_d = 1'b1;
              cnt_d   = '0;
              state_d = WAIT_SOF;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        WAIT_SOF: begin
          if (sof_i) begin
            sh_d    = first;
            cnt_d   = CW'(1);
            state_d = COLLECT;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef DESER_ERRCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_o <= '0;
    end else if (err_clr_i) begin
      err_cnt_o <= '0;
    end else if (err_o && err_cnt_o != 8'hFF) begin
      err_cnt_o <= err_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Randomised + directed bench for shift_deserializer against a queue-based
// frame model; serializer emulated by chunking words MSB first.
module tb_shift_deserializer;

  localparam int FROM = 32;
  localparam int TO   = 4;
  localparam int N    = FROM / TO;

  logic            clk = 0;
  logic            reset = 1;
  logic [TO-1:0]   data_i = '0;
  logic            valid_i = 0;
  logic            sof_i = 0;
  logic [FROM-1:0] data_o;
  logic            valid_o;
  logic            sync_o;
  logic            err_o;
`ifdef DESER_ERRCNT_EN
  logic            err_clr_i = 0;
  logic [7:0]      err_cnt_o;
`endif

  shift_deserializer #(.FROM(FROM), .LOG2FROM(5), .TO(TO)) dut (
    .clk(clk),
    .reset(reset),
    .data_i(data_i),
    .valid_i(valid_i),
    .sof_i(sof_i),
    .data_o(data_o),
    .valid_o(valid_o),
    .sync_o(sync_o),
    .err_o(err_o)
`ifdef DESER_ERRCNT_EN
    ,
    .err_clr_i(err_clr_i),
    .err_cnt_o(err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [FROM-1:0] vlog[$];
  int              errs = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: words gathered in a queue; frame is complete at N words.
  logic [TO-1:0]   mq[$];
  bit              m_hunt = 1;
  bit              m_wait = 0;
  logic [FROM-1:0] e_data = '0;
  bit              e_valid = 0;
  bit              e_err = 0;
  bit              e_sync = 0;
  int              e_cnt = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      m_hunt = 1; m_wait = 0;
      e_data = '0; e_valid = 0; e_err = 0; e_sync = 0; e_cnt = 0;
    end else begin
`ifdef DESER_ERRCNT_EN
      if (err_clr_i) e_cnt = 0;
      else if (e_err && e_cnt < 255) e_cnt++;
`endif
      e_valid = 0;
      e_err = 0;
      if (valid_i) begin
        if (sof_i) begin
          if (!m_hunt && !m_wait) e_err = 1;
          mq.delete();
          mq.push_back(data_i);
          m_hunt = 0;
          m_wait = 0;
        end else if (m_hunt) begin
          // dropped while hunting
        end else if (m_wait) begin
          e_err = 1;
          m_hunt = 1;
          m_wait = 0;
        end else begin
          mq.push_back(data_i);
          if (mq.size() == N) begin
            e_data = '0;
            foreach (mq[i]) e_data = (e_data << TO) | FROM'(mq[i]);
            e_valid = 1;
            mq.delete();
            m_wait = 1;
          end
        end
      end
      e_sync = !m_hunt;
    end
  end

  // Compare process, every cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    check("data_o", data_o, e_data);
    check("valid_o", 32'(valid_o), 32'(e_valid));
    check("err_o", 32'(err_o), 32'(e_err));
    check("sync_o", 32'(sync_o), 32'(e_sync));
`ifdef DESER_ERRCNT_EN
    check("err_cnt_o", 32'(err_cnt_o), 32'(e_cnt));
`endif
    if (valid_o) vlog.push_back(data_o);
    if (err_o) errs++;
  end

  task automatic send(input logic [TO-1:0] d, input logic s);
    @(posedge clk); #1;
    valid_i = 1; data_i = d; sof_i = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_i = 0; sof_i = 0; data_i = 4'($urandom);
    end
  endtask

  task automatic frame(input logic [FROM-1:0] w, input int gap_at);
    for (int k = 0; k < N; k++) begin
      if (k == gap_at) idle(2);
      send(w[FROM-1-TO*k -: TO], k == 0);
    end
  endtask

  task automatic settle();
    @(negedge clk); #2;
  endtask

  task automatic clear_log();
    vlog.delete();
    errs = 0;
  endtask

  logic [FROM-1:0] words[10];

  initial begin
    repeat (2) @(negedge clk);
    check("rst data_o", data_o, 32'h0);
    check("rst flags", {28'h0, valid_o, sync_o, err_o, 1'b0}, 32'h0);
    reset = 0;

    // Frame 1..8
    clear_log();
    frame(32'h12345678, -1);
    idle(1);
    settle();
    check("t1 valid_o", 32'(valid_o), 32'h1);
    check("t1 data_o", data_o, 32'h12345678);
    check("t1 err/sync", {30'h0, err_o, sync_o}, 32'h1);
    idle(1);
    settle();
    check("t1 pulse", 32'(valid_o), 32'h0);

    // Back-to-back frames with gaps inside
    clear_log();
    frame(32'h87654321, 3);
    frame(32'hABCDEF03, 5);
    idle(2);
    settle();
    check("t2 count", 32'(vlog.size()), 32'h2);
    if (vlog.size() == 2) begin
      check("t2 frame0", vlog[0], 32'h87654321);
      check("t2 frame1", vlog[1], 32'hABCDEF03);
    end
    check("t2 errs", 32'(errs), 32'h0);

    // Early SOF after 3 words
    clear_log();
    send(4'h1, 1); send(4'h2, 0); send(4'h3, 0);
    frame(32'h98765432, -1);
    idle(2);
    settle();
    check("t3 errs", 32'(errs), 32'h1);
    check("t3 count", 32'(vlog.size()), 32'h1);
    if (vlog.size() == 1) check("t3 frame", vlog[0], 32'h98765432);
    check("t3 sync", 32'(sync_o), 32'h1);

    // Stray word after a frame loses sync
    clear_log();
    send(4'h5, 0);
    idle(1);
    settle();
    check("t4 err", 32'(err_o), 32'h1);
    check("t4 sync", 32'(sync_o), 32'h0);
    send(4'h6, 0); send(4'h7, 0); send(4'h8, 0);
    idle(1);
    settle();
    check("t4 hunt errs", 32'(errs), 32'h1);
    check("t4 hunt valid", 32'(vlog.size()), 32'h0);
    frame(32'hC0FFEE11, -1);
    idle(1);
    settle();
    check("t4 resync", 32'(sync_o), 32'h1);
    check("t4 data", data_o, 32'hC0FFEE11);

    // Reset mid-frame
    clear_log();
    for (int k = 0; k < 5; k++) send(4'(k + 1), k == 0);
    idle(1);
    @(negedge clk);
    reset = 1;
    #1;
    check("t5 rst data", data_o, 32'h0);
    check("t5 rst flags", {29'h0, valid_o, sync_o, err_o}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 0;
    frame(32'hFEDCBA98, -1);
    idle(2);
    settle();
    check("t5 count", 32'(vlog.size()), 32'h1);
    if (vlog.size() == 1) check("t5 frame", vlog[0], 32'hFEDCBA98);

    // Loopback: serializer emulation, continuous valid
    clear_log();
    foreach (words[i]) words[i] = $urandom;
    foreach (words[i]) frame(words[i], -1);
    idle(2);
    settle();
    check("t6 count", 32'(vlog.size()), 32'd10);
    for (int i = 0; i < 10 && i < vlog.size(); i++)
      check("t6 word", vlog[i], words[i]);
    check("t6 errs", 32'(errs), 32'h0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) != 0) send(4'($urandom), $urandom_range(0, 7) == 0);
      else idle(1);
    end
    idle(2);

`ifdef DESER_ERRCNT_EN
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int k = 0; k < 301; k++) send(4'(k), 1);
    idle(3);
    settle();
    check("errcnt sat", 32'(err_cnt_o), 32'hFF);
    @(posedge clk); #1;
    err_clr_i = 1;
    @(posedge clk); #1;
    err_clr_i = 0;
    settle();
    check("errcnt clr", 32'(err_cnt_o), 32'h0);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Receive-side counterpart to shift_serializer: reassembles a stream of TO-bit words into FROM-bit words.
- Sits directly downstream of the serializer, at the far end of the narrow link.
- Framing comes from a start-of-frame marker. The marker is the serializer's ready_o delayed by one clk, because serializer data appears one cycle after its load.
- Tracks alignment, flags framing errors, and emits each reassembled word with a one-cycle valid pulse.

Parameters:
- FROM, 32, width of the reassembled output word.
- LOG2FROM, 5, log2(FROM); sets the counter width (LOG2FROM+1 bits).
- TO, 4, width of the serial input word. TO divides FROM; N = FROM/TO >= 2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- data_i  input  TO  serial input word.
- valid_i  input  1  data_i/sof_i qualified this cycle.
- sof_i  input  1  data_i is the first word of a frame; ignored when valid_i=0.
- data_o  output  FROM  last completed frame.
- valid_o  output  1  one-cycle pulse: data_o newly updated.
- sync_o  output  1  block is frame-aligned.
- err_o  output  1  one-cycle pulse: framing error detected.

Behaviour:
- Reset (async, active-high) values:
  - state=HUNT, cnt=0, shift register=0.
  - data_o=0, valid_o=0, sync_o=0, err_o=0.
  - Reset mid-frame discards the partial frame; no valid_o follows.
- Accepted word means valid_i=1 at a rising clk. Cycles with valid_i=0 change nothing except clearing the valid_o and err_o pulses. Gaps are allowed anywhere.
- Word order, MSB chunk first, matching the serializer:
  - the first word of a frame lands in data_o[FROM-1:FROM-TO];
  - the Nth word lands in data_o[TO-1:0].
  - Shift rule: sh <= {sh[FROM-TO-1:0], data_i}.
- States:
  - HUNT (sync_o=0):
    - accepted word with sof_i=0: dropped, no err;
    - accepted word with sof_i=1: sh loaded, cnt=1, go to COLLECT.
  - COLLECT (sync_o=1):
    - accepted word with sof_i=0: shift in, cnt+1;
    - when this is word N: registered next cycle data_o=frame, valid_o=1, cnt=0, go to WAIT_SOF;
    - accepted word with sof_i=1 (cnt 1..N-1): err_o pulse; partial frame dropped; restart with this word as word 1 (cnt=1); stay in COLLECT; sync_o stays 1.
  - WAIT_SOF (sync_o=1):
    - accepted word with sof_i=1: start new frame, cnt=1, go to COLLECT;
    - accepted word with sof_i=0: err_o pulse, word dropped, go to HUNT (sync_o=0 next cycle).
- Latency: valid_o and data_o are registered outputs, one clk after the Nth word is accepted. Back-to-back frames need no idle cycle: the SOF word of frame k+1 may arrive the cycle after word N of frame k.
- data_o holds its value between valid_o pulses.
- err_o and valid_o are never asserted in the same cycle.
- Counter:
  - LOG2FROM+1 bits; range 0..N-1.
  - Compare against N-1 for completion; never wraps past N.
- N=2 is legal: SOF word plus one further word completes the frame.

Optional Feature:
- Macro: DESER_ERRCNT_EN.
- Defined:
  - adds output err_cnt_o [7:0], an 8-bit saturating count of err_o pulses;
  - reset 0; increments in the cycle after each err_o pulse;
  - holds at 8'hFF.
  - Adds input err_clr_i [1 bit]: synchronous clear. err_clr_i takes priority over a simultaneous increment.
- Undefined: no err_cnt_o or err_clr_i ports, no counter logic. All other behaviour is identical.

Test Plan (FROM=32, TO=4, N=8):
- Reset, then valid_i=1 with words 1,2,...,8 and sof_i on word 1 -> one cycle after word 8: valid_o=1 for one cycle, data_o=32'h12345678, err_o=0, sync_o=1.
- Two back-to-back frames (8..1, then A..3) with valid_i low for 2 cycles inside each frame -> two valid_o pulses, data_o=32'h87654321 then 32'hABCDEF03, no err.
- 3 words of a frame, then a word with sof_i=1 followed by 7 more -> err_o pulses once (cycle after the second SOF). The second frame alone appears on data_o. sync_o stays 1.
- After a completed frame, a valid word with sof_i=0 -> err_o pulse, sync_o=0. The following non-SOF words produce no err and no valid. The next SOF frame restores sync_o=1 and completes normally.
- Assert reset after word 5 of a frame, release, then a full frame of 8'h... words -> all outputs 0 during reset; only the new frame produces valid_o.
- Loopback: shift_serializer (same parameters) drives data_i, with sof_i = its ready_o delayed 1 clk and valid_i=1. Ten random input words -> data_o matches each serializer input in order, no err_o. With DESER_ERRCNT_EN defined: forcing 300 framing errors gives err_cnt_o=8'hFF, and err_clr_i returns it to 0.
